// File: rtl/stopwatch_cu_pkg.sv
// Shared encodings and defaults for the stopwatch control unit.
// The datapath-side decode imports the same package so state codes stay in one place.
package stopwatch_cu_pkg;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // 1 ms of stable level at 100 MHz
    localparam int DEBOUNCE_COUNT_DEF = 100_000;
    localparam int SYNC_STAGES_DEF    = 2;

endpackage

// File: rtl/stopwatch_cu_btn_debounce.sv
// One push-button front end: synchroniser, consecutive-cycle debounce, and a rising-edge
// pulse that fires once per accepted press.
module btn_debounce
    import stopwatch_cu_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   prev_q, prev_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_btn};
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        // Any cycle of agreement restarts the count, so short glitches never accumulate.
        if (sync_bit != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_COUNT - 1)) begin
                level_d = sync_bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    assign o_level = level_q;
    assign o_pulse = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: debounced RUN/STOP and CLEAR buttons drive a STOP/RUN/CLEAR FSM
// whose outputs are a Moore decode of the state register.
module stopwatch_cu
    import stopwatch_cu_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_runstop,
    input  logic       i_btn_clear,
    output logic       o_runstop,
    output logic       o_clear,
    output logic [1:0] o_state
);

    logic   rs_pulse, clr_pulse;
    state_e state_q, state_d;

    btn_debounce #(
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_db_runstop (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn_runstop),
        .o_level(),
        .o_pulse(rs_pulse)
    );

    btn_debounce #(
        .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_db_clear (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn_clear),
        .o_level(),
        .o_pulse(clr_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_STOP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Clear has priority over run when both land together.
            ST_STOP: begin
                if (clr_pulse)     state_d = ST_CLEAR;
                else if (rs_pulse) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (rs_pulse) state_d = ST_STOP;
            end
            ST_CLEAR: state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        o_runstop = (state_q == ST_RUN);
        o_clear   = (state_q == ST_CLEAR);
        o_state   = state_q;
    end

endmodule
